// File: rtl/as6s_vp_buffer_fifo_ctrl.sv
// FIFO controller driving the as6s 1r1w ECC RAM wrapper: push stream -> RAM writes,
// prefetch reads absorbed in a small output buffer, pop stream with ECC status and statistics.
module as6s_vp_buffer_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 128,
    parameter int RD_LATENCY = 2,
    parameter int OBUF_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_sbit_err,
    output logic                  rd_dbit_err,
    output logic [ADDR_WIDTH-1:0] ram_aa,
    output logic                  ram_csa,
    output logic                  ram_wea,
    output logic [DATA_WIDTH-1:0] ram_da,
    output logic [ADDR_WIDTH-1:0] ram_ab,
    output logic                  ram_csb,
    output logic                  ram_reb,
    input  logic [DATA_WIDTH-1:0] ram_qb,
    input  logic                  ram_single_err,
    input  logic                  ram_double_err,
    input  logic                  ram_ecc_fault,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH+1:0] fifo_cnt,
    output logic [CNT_WIDTH-1:0]  sbit_err_cnt,
    output logic                  dbit_err_sticky,
    output logic                  ecc_fault_sticky
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int OB_AW     = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int OB_CW     = $clog2(OBUF_DEPTH + 1);

    typedef struct packed {
        logic                  dbit;
        logic                  sbit;
        logic [DATA_WIDTH-1:0] data;
    } obuf_entry_t;

    logic                  init_r;
    logic [ADDR_WIDTH:0]   wptr, rptr, ram_cnt;
    logic                  ram_full_r;
    logic                  push, pop, rd_issue, capture;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [OB_CW-1:0]      inflight, obuf_cnt;
    logic [OB_AW-1:0]      ob_wr, ob_rd;
    obuf_entry_t           obuf_mem [OBUF_DEPTH];
    obuf_entry_t           head;

    // Both streams transfer a word on a cycle where valid and ready are high together;
    // ready never depends combinationally on valid.
    assign ram_cnt    = wptr - rptr;
    assign ram_full_r = (ram_cnt == (ADDR_WIDTH+1)'(RAM_DEPTH));
    assign wr_rdy     = init_r & ~ram_full_r;
    assign push       = wr_vld & wr_rdy;
    assign rd_vld     = (obuf_cnt != '0);
    assign pop        = rd_vld & rd_rdy;
    assign inflight   = OB_CW'($countones(vld_sr));
    assign capture    = vld_sr[RD_LATENCY-1];

    // Reserving buffer space at issue time guarantees every returning word has a slot.
    assign rd_issue = (ram_cnt != '0) && ((int'(inflight) + int'(obuf_cnt)) < OBUF_DEPTH);

    assign ram_csa = push;
    assign ram_wea = push;
    assign ram_aa  = push ? wptr[ADDR_WIDTH-1:0] : '0;
    assign ram_da  = push ? wr_data : '0;
    assign ram_csb = rd_issue;
    assign ram_reb = rd_issue;
    assign ram_ab  = rd_issue ? rptr[ADDR_WIDTH-1:0] : '0;

    assign head        = obuf_mem[ob_rd];
    assign rd_data     = rd_vld ? head.data : '0;
    assign rd_sbit_err = rd_vld & head.sbit;
    assign rd_dbit_err = rd_vld & head.dbit;

    assign fifo_cnt = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(inflight)
                    + (ADDR_WIDTH+2)'(obuf_cnt);

    function automatic logic [OB_AW-1:0] ob_next(input logic [OB_AW-1:0] p);
        return (p == OB_AW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_r   <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            vld_sr   <= '0;
            ob_wr    <= '0;
            ob_rd    <= '0;
            obuf_cnt <= '0;
        end else begin
            init_r <= 1'b1;
            if (push)     wptr <= wptr + 1'b1;
            if (rd_issue) rptr <= rptr + 1'b1;
            vld_sr <= {vld_sr[RD_LATENCY-2:0], rd_issue};
            if (capture)  ob_wr <= ob_next(ob_wr);
            if (pop)      ob_rd <= ob_next(ob_rd);
            case ({capture, pop})
                2'b10:   obuf_cnt <= obuf_cnt + 1'b1;
                2'b01:   obuf_cnt <= obuf_cnt - 1'b1;
                default: obuf_cnt <= obuf_cnt;
            endcase
        end
    end

    // Payload storage needs no reset: the read side is gated by rd_vld.
    always_ff @(posedge clk) begin
        if (capture) begin
            obuf_mem[ob_wr] <= '{dbit: ram_double_err, sbit: ram_single_err, data: ram_qb};
        end
    end

    // A new error in the same cycle as err_clr still registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbit_err_cnt     <= '0;
            dbit_err_sticky  <= 1'b0;
            ecc_fault_sticky <= 1'b0;
        end else begin
            if (capture && ram_single_err) begin
                if (err_clr)            sbit_err_cnt <= CNT_WIDTH'(1);
                else if (!(&sbit_err_cnt)) sbit_err_cnt <= sbit_err_cnt + 1'b1;
            end else if (err_clr) begin
                sbit_err_cnt <= '0;
            end
            if (capture && ram_double_err) dbit_err_sticky <= 1'b1;
            else if (err_clr)              dbit_err_sticky <= 1'b0;
            if (capture && ram_ecc_fault)  ecc_fault_sticky <= 1'b1;
            else if (err_clr)              ecc_fault_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_as6s_vp_buffer_fifo_ctrl.sv
// Bench for as6s_vp_buffer_fifo_ctrl: behavioural wrapper RAM with error injection,
// expected-word queue and error statistics model.
module tb_as6s_vp_buffer_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_vld = 1'b0, rd_rdy = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_rdy, rd_vld, rd_sbit_err, rd_dbit_err;
    logic [DW-1:0] rd_data, ram_da;
    logic [AW-1:0] ram_aa, ram_ab;
    logic          ram_csa, ram_wea, ram_csb, ram_reb;
    logic [DW-1:0] ram_qb = '0;
    logic          ram_single_err = 1'b0, ram_double_err = 1'b0, ram_ecc_fault = 1'b0;
    logic [AW+1:0] fifo_cnt;
    logic [7:0]    sbit_err_cnt;
    logic          dbit_err_sticky, ecc_fault_sticky;

    as6s_vp_buffer_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data),
        .rd_sbit_err(rd_sbit_err), .rd_dbit_err(rd_dbit_err),
        .ram_aa(ram_aa), .ram_csa(ram_csa), .ram_wea(ram_wea), .ram_da(ram_da),
        .ram_ab(ram_ab), .ram_csb(ram_csb), .ram_reb(ram_reb), .ram_qb(ram_qb),
        .ram_single_err(ram_single_err), .ram_double_err(ram_double_err),
        .ram_ecc_fault(ram_ecc_fault), .err_clr(err_clr),
        .fifo_cnt(fifo_cnt), .sbit_err_cnt(sbit_err_cnt),
        .dbit_err_sticky(dbit_err_sticky), .ecc_fault_sticky(ecc_fault_sticky)
    );

    always #5 clk = ~clk;

    // Wrapper model: registered RAM read plus output flop; flags {ecc, dbit, sbit} travel with each word.
    logic [DW-1:0] mem [16];
    logic [2:0]    mem_flg [16];
    logic [2:0]    inj_flags = 3'b0;
    logic [DW-1:0] s1_data = '0;
    logic [2:0]    s1_flg = 3'b0;

    always @(posedge clk) begin
        if (ram_csa && ram_wea) begin
            mem[ram_aa]     <= ram_da;
            mem_flg[ram_aa] <= inj_flags;
        end
        s1_data <= (ram_csb && ram_reb) ? mem[ram_ab] : '0;
        s1_flg  <= (ram_csb && ram_reb) ? mem_flg[ram_ab] : 3'b0;
        ram_qb  <= s1_data;
        {ram_ecc_fault, ram_double_err, ram_single_err} <= s1_flg;
    end

    logic [129:0] exp_q[$];
    int n_assert = 0, n_fail = 0;
    int exp_sbit = 0;
    bit exp_dbit = 1'b0, exp_ecc = 1'b0;
    int n_push = 0, n_pop = 0;
    logic [AW-1:0] last_aa;
    logic          last_csa;

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle, entered and left at a falling edge.
    task automatic tick(input bit do_push, input bit do_pop, input logic [DW-1:0] d,
                        input logic [2:0] flg);
        logic [129:0] e;
        wr_vld = do_push; wr_data = d; rd_rdy = do_pop; inj_flags = flg;
        #1;
        last_aa = ram_aa; last_csa = ram_csa;
        chk("fifo_cnt", 130'(fifo_cnt), 130'(exp_q.size()));
        if (do_pop && rd_vld) begin
            if (exp_q.size() == 0) chk("rd_vld_when_empty", 130'(rd_vld), 130'(0));
            else begin
                e = exp_q.pop_front();
                chk("rd_word", {rd_dbit_err, rd_sbit_err, rd_data}, e);
            end
            n_pop++;
        end
        if (do_push && wr_rdy) begin
            exp_q.push_back({flg[1], flg[0], d});
            n_push++;
            if (flg[0] && exp_sbit < 255) exp_sbit++;
            if (flg[1]) exp_dbit = 1'b1;
            if (flg[2]) exp_ecc = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick(1'b0, 1'b1, '0, 3'b0);
        chk("drain_left", 130'(exp_q.size()), 130'(0));
        #1 chk("drain_fifo_cnt", 130'(fifo_cnt), 130'(0));
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_sbit_cnt"}, 130'(sbit_err_cnt), 130'(exp_sbit));
        chk({tag, "_dbit_sticky"}, 130'(dbit_err_sticky), 130'(exp_dbit));
        chk({tag, "_ecc_sticky"}, 130'(ecc_fault_sticky), 130'(exp_ecc));
    endtask

    task automatic clear_stats();
        err_clr = 1'b1;
        tick(1'b0, 1'b0, '0, 3'b0);
        err_clr = 1'b0;
        exp_sbit = 0; exp_dbit = 1'b0; exp_ecc = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_rdy"}, 130'(wr_rdy), 130'(0));
        chk({tag, "_rd_vld"}, 130'(rd_vld), 130'(0));
        chk({tag, "_rd_word"}, {rd_dbit_err, rd_sbit_err, rd_data}, 130'(0));
        chk({tag, "_ram_a"}, {ram_csa, ram_wea, ram_aa, ram_da}, 130'(0));
        chk({tag, "_ram_b"}, 130'({ram_csb, ram_reb, ram_ab}), 130'(0));
        chk({tag, "_fifo_cnt"}, 130'(fifo_cnt), 130'(0));
        chk({tag, "_stats"}, 130'({sbit_err_cnt, dbit_err_sticky, ecc_fault_sticky}), 130'(0));
    endtask

    task automatic release_reset(input string tag);
        rst_n = 1'b1;
        #1 chk({tag, "_wr_rdy_at_release"}, 130'(wr_rdy), 130'(0));
        @(negedge clk);
        chk({tag, "_wr_rdy_after_release"}, 130'(wr_rdy), 130'(1));
    endtask

    initial begin : main
        logic [DW-1:0] d;
        logic [2:0]    f;
        int            p0, q0;
        bit            found;
        logic [2:0]    err_tbl [8];
        err_tbl = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b100};

        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        release_reset("init");

        // Single word latency through an empty FIFO.
        d = {16{8'hA5}};
        wr_vld = 1'b1; wr_data = d; rd_rdy = 1'b1; inj_flags = 3'b0;
        #1 chk("lat_write_cmd", {ram_csa, ram_wea, ram_aa, ram_da}, {1'b1, 1'b1, 4'd0, d});
        exp_q.push_back({2'b00, d});
        @(negedge clk);
        wr_vld = 1'b0;
        chk("lat_read_cmd", 130'({ram_csb, ram_reb, ram_ab}), 130'({1'b1, 1'b1, 4'd0}));
        for (int c = 1; c <= 3; c++) begin
            chk("lat_rd_vld_low", 130'(rd_vld), 130'(0));
            @(negedge clk);
        end
        chk("lat_rd_vld_high", 130'(rd_vld), 130'(1));
        tick(1'b0, 1'b1, '0, 3'b0);
        chk("lat_fifo_cnt_zero", 130'(fifo_cnt), 130'(0));

        // Fill to capacity, release by one pop, drain in order across the address wrap.
        rst_n = 1'b0; @(negedge clk); release_reset("fill");
        p0 = n_push;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, DW'(i), 3'b0);
            if (i == 16) chk("wrap_aa", 130'({last_csa, last_aa}), 130'({1'b1, 4'd0}));
        end
        chk("fill_accepted", 130'(n_push - p0), 130'(20));
        chk("full_wr_rdy", 130'(wr_rdy), 130'(0));
        chk("full_fifo_cnt", 130'(fifo_cnt), 130'(20));
        tick(1'b0, 1'b1, '0, 3'b0);
        chk("full_wr_rdy_pop_plus1", 130'(wr_rdy), 130'(0));
        tick(1'b0, 1'b0, '0, 3'b0);
        chk("full_wr_rdy_pop_plus2", 130'(wr_rdy), 130'(1));
        drain();

        // Streaming: one push and one pop per cycle after the initial fill latency.
        p0 = n_push; q0 = n_pop;
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b1, rnd128(), 3'b0);
        chk("stream_pushes", 130'(n_push - p0), 130'(100));
        chk("stream_pops", 130'(n_pop - q0), 130'(96));
        drain();

        // Per-word error flags and statistics, then clear.
        clear_stats();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, rnd128(), err_tbl[i]);
        drain();
        check_stats("inj");
        clear_stats();
        check_stats("inj_clr");

        // Saturation of the single-bit counter.
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b1, rnd128(), 3'b001);
        drain();
        check_stats("sat");
        chk("sat_value", 130'(sbit_err_cnt), 130'(8'hFF));

        // err_clr coinciding with a returning single-bit error.
        clear_stats();
        tick(1'b1, 1'b0, rnd128(), 3'b001);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (ram_single_err === 1'b1) begin
                found = 1'b1;
                err_clr = 1'b1;
                tick(1'b0, 1'b0, '0, 3'b0);
                err_clr = 1'b0;
            end else tick(1'b0, 1'b0, '0, 3'b0);
        end
        chk("collide_seen", 130'(found), 130'(1));
        chk("collide_sbit_cnt", 130'(sbit_err_cnt), 130'(1));
        drain();

        // Random traffic with sporadic errors.
        clear_stats();
        for (int i = 0; i < 200; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd128(), f);
        end
        drain();
        check_stats("rand");

        // Asynchronous reset with reads in flight and words stored.
        clear_stats();
        tick(1'b1, 1'b0, rnd128(), 3'b110);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, rnd128(), 3'b0);
        check_stats("pre_rst");
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        exp_q.delete();
        exp_sbit = 0; exp_dbit = 1'b0; exp_ecc = 1'b0;
        @(negedge clk); @(negedge clk);
        wr_vld = 1'b0;
        release_reset("mid_rst");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, rnd128(), 3'b0);
        drain();
        check_stats("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/as6s_vp_buffer_fifo_ctrl.md
# as6s_vp_buffer_fifo_ctrl

Single-clock FIFO controller that acts as the initiator for the as6s 1r1w ECC RAM wrapper. It turns a valid/ready push stream into wrapper write commands and issues prefetch reads. It absorbs the wrapper's 2-cycle read latency in a 4-entry output buffer and presents a valid/ready pop stream with per-word ECC status. It also keeps ECC error statistics for the VP buffer status registers.

## Interface
Parameters:
- ADDR_WIDTH, 4: RAM address width; RAM_DEPTH = 1<<ADDR_WIDTH.
- DATA_WIDTH, 128: payload width.
- RD_LATENCY, 2: cycles from read command to ram_qb/error flags valid; fixed by the wrapper's registered RAM output plus output flop.
- OBUF_DEPTH, 4: output buffer entries; must be ≥ RD_LATENCY+1.
- CNT_WIDTH, 8: width of the single-bit error counter.

Ports:
- clk, in, 1: single clock. It drives both w_clk and r_clk of the wrapper.
- rst_n, in, 1: reset, asynchronous, active-low.
- wr_vld, in, 1: push request.
- wr_rdy, out, 1: push accepted when wr_vld & wr_rdy.
- wr_data, in, DATA_WIDTH: push payload.
- rd_vld, out, 1: pop data available.
- rd_rdy, in, 1: consumer accepts when rd_vld & rd_rdy.
- rd_data, out, DATA_WIDTH: head word.
- rd_sbit_err, out, 1: head word had a corrected single-bit error.
- rd_dbit_err, out, 1: head word had an uncorrectable error; data is unreliable.
- ram_aa, out, ADDR_WIDTH: wrapper AA_F.
- ram_csa, out, 1: wrapper CSA_F.
- ram_wea, out, 1: wrapper WEA_F.
- ram_da, out, DATA_WIDTH: wrapper DA_F.
- ram_ab, out, ADDR_WIDTH: wrapper AB_F.
- ram_csb, out, 1: wrapper CSB_F.
- ram_reb, out, 1: wrapper REB_F.
- ram_qb, in, DATA_WIDTH: wrapper QB_F.
- ram_single_err, in, 1: wrapper SINGLE_ERR_B.
- ram_double_err, in, 1: wrapper DOUBLE_ERR_B.
- ram_ecc_fault, in, 1: wrapper ECC_FAULT_B.
- err_clr, in, 1: clears the error counter and sticky flags.
- fifo_cnt, out, ADDR_WIDTH+2: total words held (RAM + in-flight + obuf).
- sbit_err_cnt, out, CNT_WIDTH: saturating count of single-bit errors.
- dbit_err_sticky, out, 1: any double-bit error since the last clear.
- ecc_fault_sticky, out, 1: any ECC logic fault since the last clear.

## Operation
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits, with the MSB as the wrap bit.
  - ram_cnt = wptr - rptr (modulo).
  - RAM full when ram_cnt == RAM_DEPTH.
- Write path:
  - wr_rdy = init_r & ~ram_full_r.
  - On a push: ram_csa = ram_wea = 1, ram_aa = wptr[ADDR_WIDTH-1:0], ram_da = wr_data, combinationally in the same cycle.
  - wptr increments at the clock edge.
- Read issue:
  - Condition: ram_cnt != 0 (registered pointers) and inflight + obuf_cnt < OBUF_DEPTH.
  - On issue: ram_csb = ram_reb = 1, ram_ab = rptr[ADDR_WIDTH-1:0], and rptr increments.
  - A read never targets the address written in the same cycle, so the wrapper's same-address error masking is never triggered.
- In-flight tracking:
  - An RD_LATENCY-deep valid shift register tracks issued reads.
  - When a valid bit exits, ram_qb and the three error inputs are captured into obuf.
- Output buffer:
  - 4-entry FIFO of {dbit, sbit, data}.
  - rd_vld = obuf non-empty; rd_* reflects the head.
  - Pop on rd_vld & rd_rdy.
- Statistics, on each captured word:
  - single_err increments sbit_err_cnt, saturating at all-ones.
  - double_err sets dbit_err_sticky.
  - ecc_fault sets ecc_fault_sticky.
  - err_clr clears all three. If a set and err_clr occur in the same cycle, the set wins (count becomes 1).
- fifo_cnt = ram_cnt + inflight + obuf_cnt.
  - Maximum is RAM_DEPTH + OBUF_DEPTH = 20.

## Timing
- Reset values:
  - wr_rdy, rd_vld, rd_sbit_err, rd_dbit_err = 0.
  - rd_data = 0.
  - All ram_* outputs = 0.
  - fifo_cnt, sbit_err_cnt = 0; both stickies = 0.
- init_r is set on the first clk edge after rst_n release, so wr_rdy rises one cycle after release.
- Latency, empty FIFO:
  - Push at cycle t: write to RAM at t.
  - Read issued at t+1.
  - ram_qb valid at t+3, captured at the t+3 edge.
  - rd_vld = 1 at t+4.
- Throughput: one push and one pop per cycle sustained. Simultaneous push and pop leave fifo_cnt unchanged.
- A full RAM with a full obuf holds wr_rdy = 0. A pop frees an obuf slot, a read issues the next cycle, and wr_rdy returns the cycle after that.
- Wrap-around: pointers roll from 15 to 0 with the MSB toggling. Ordering is preserved across the wrap.
- Reset mid-operation clears all state asynchronously. In-flight reads are discarded, and ram_qb is ignored until new reads are issued.

## Test plan
- Push 1 word 0xA5…A5 into an empty FIFO, rd_rdy = 1 → ram_csb pulses at t+1, rd_vld at t+4 with data 0xA5…A5 and no error flags, fifo_cnt returns to 0.
- Push 20 words with rd_rdy = 0 → wr_rdy drops after the 20th push and fifo_cnt = 20. Drain at full rate → data returns in order 0..19, addresses wrap 15→0.
- Back-to-back push and pop for 100 cycles with random data → one word per cycle, no bubbles after the first fill, scoreboard matches.
- Inject ram_single_err on 3 read returns and ram_double_err on 1 → sbit_err_cnt = 3, dbit_err_sticky = 1, rd_sbit_err/rd_dbit_err set on exactly those words. err_clr → all 0.
- Force 300 single errors → sbit_err_cnt saturates at 255. err_clr in the same cycle as an error → count = 1.
- Assert rst_n low with 2 reads in flight and 5 words stored → all outputs reset immediately. After release, the first push/pop returns only new data.
